pipe_sink: RTL and testbench

PIPE_SINK -- requirements
Module: pipe_sink

---
 rtl/pipe_sink.sv | 119 +++++++++++
 tb/tb_pipe_sink.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sink.sv
// Frame-checking sink: validates start/stop framing on an incoming beat stream
// and buffers accepted beats in a first-word-fall-through FIFO.
module pipe_sink #(
    parameter int Width = 8,
    parameter int Depth = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [Width-1:0] pipe_in_data,
    input  logic             pipe_in_start,
    input  logic             pipe_in_stop,
    input  logic             pipe_in_valid,
    output logic             pipe_in_ready,
    output logic [Width-1:0] out_data,
    output logic             out_start,
    output logic             out_stop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      frame_count,
    output logic             frame_error
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic             start;
        logic             stop;
        logic [Width-1:0] data;
    } beat_t;

    typedef enum logic {
        IDLE,
        IN_FRAME
    } state_e;

    beat_t          mem_q [Depth];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    state_e         state_q, state_d;
    logic [15:0]    frame_count_q, frame_count_d;
    logic           frame_error_q, frame_error_d;
    logic           accept;
    logic           pop;
    logic           store;
    beat_t          head;

    // Ready looks only at the stored count, so a pop never frees a slot in the same cycle.
    assign pipe_in_ready = ~reset & (count_q != CW'(Depth));
    assign accept        = pipe_in_valid & pipe_in_ready;
    assign out_valid     = (count_q != '0);
    assign pop           = out_valid & out_ready;

    // Head payload is masked while empty because the storage array holds stale data.
    assign head      = mem_q[rd_ptr_q];
    assign out_data  = out_valid ? head.data  : '0;
    assign out_start = out_valid ? head.start : 1'b0;
    assign out_stop  = out_valid ? head.stop  : 1'b0;

    assign frame_count = frame_count_q;
    assign frame_error = frame_error_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d       = state_q;
        frame_count_d = frame_count_q;
        frame_error_d = 1'b0;
        store         = 1'b0;
        if (accept) begin
            if (pipe_in_start) begin
                // A start inside an open frame abandons that frame and opens a new one.
                store         = 1'b1;
                frame_error_d = (state_q == IN_FRAME);
                state_d       = pipe_in_stop ? IDLE : IN_FRAME;
                if (pipe_in_stop) frame_count_d = frame_count_q + 16'd1;
            end else if (state_q == IN_FRAME) begin
                store = 1'b1;
                if (pipe_in_stop) begin
                    state_d       = IDLE;
                    frame_count_d = frame_count_q + 16'd1;
                end
            end else begin
                frame_error_d = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(store);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(store) - CW'(pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= IDLE;
            frame_count_q <= '0;
            frame_error_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            frame_count_q <= frame_count_d;
            frame_error_q <= frame_error_d;
        end
    end

    // NOTE: the storage array is not reset; count_q and the output masking make its contents invisible.
    always_ff @(posedge clock) begin
        if (store) mem_q[wr_ptr_q] <= '{start: pipe_in_start, stop: pipe_in_stop, data: pipe_in_data};
    end

endmodule

// File: tb/tb_pipe_sink.sv
// Directed testbench for pipe_sink: framing, FIFO full/empty behaviour,
// counter wrap and asynchronous reset.
module tb_pipe_sink;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  pipe_in_data;
    logic        pipe_in_start;
    logic        pipe_in_stop;
    logic        pipe_in_valid;
    logic        pipe_in_ready;
    logic [7:0]  out_data;
    logic        out_start;
    logic        out_stop;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] frame_count;
    logic        frame_error;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_sink #(.Width(8), .Depth(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .pipe_in_data  (pipe_in_data),
        .pipe_in_start (pipe_in_start),
        .pipe_in_stop  (pipe_in_stop),
        .pipe_in_valid (pipe_in_valid),
        .pipe_in_ready (pipe_in_ready),
        .out_data      (out_data),
        .out_start     (out_start),
        .out_stop      (out_stop),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .frame_count   (frame_count),
        .frame_error   (frame_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic s, input logic p);
        pipe_in_valid = 1'b1;
        pipe_in_data  = d;
        pipe_in_start = s;
        pipe_in_stop  = p;
    endtask

    task automatic idle_in();
        pipe_in_valid = 1'b0;
        pipe_in_data  = '0;
        pipe_in_start = 1'b0;
        pipe_in_stop  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        idle_in();
        tick();
        tick();
        check("rst_ready", pipe_in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_fcount", frame_count, 0);
        check("rst_ferr", frame_error, 0);
        reset = 1'b0;
        #1;
        check("rel_ready", pipe_in_ready, 1);

        // Three-beat frame streamed straight through.
        out_ready = 1'b1;
        drive(8'h11, 1, 0);
        tick();
        check("f1_b0_valid", out_valid, 1);
        check("f1_b0", {out_start, out_stop, out_data}, {2'b10, 8'h11});
        drive(8'h22, 0, 0);
        tick();
        check("f1_b1", {out_start, out_stop, out_data}, {2'b00, 8'h22});
        drive(8'h33, 0, 1);
        tick();
        check("f1_b2", {out_start, out_stop, out_data}, {2'b01, 8'h33});
        check("f1_fcount", frame_count, 1);
        check("f1_ferr", frame_error, 0);
        idle_in();
        tick();
        check("f1_empty", out_valid, 0);
        check("f1_empty_data", out_data, 0);
        tick();
        check("underflow_valid", out_valid, 0);

        // Fill to Depth with the consumer stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(8'h80 + 8'(i), (i == 0), 0);
            tick();
        end
        check("full_ready", pipe_in_ready, 0);
        check("full_head", out_data, 8'h80);
        drive(8'h88, 0, 1);
        tick();
        check("held_ready", pipe_in_ready, 0);
        check("held_fcount", frame_count, 1);
        out_ready = 1'b1;
        tick();
        check("freed_ready", pipe_in_ready, 1);
        check("freed_head", out_data, 8'h81);
        out_ready = 1'b0;
        tick();
        check("refull_ready", pipe_in_ready, 0);
        check("f2_fcount", frame_count, 2);
        idle_in();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain_%0d", i), {out_valid, out_stop, out_data},
                  {1'b1, (i == 8), 8'h80 + 8'(i)});
            tick();
        end
        check("drain_empty", out_valid, 0);

        // Beat without start while idle is dropped.
        drive(8'h55, 0, 0);
        tick();
        check("drop_valid", out_valid, 0);
        check("drop_ferr", frame_error, 1);
        check("drop_ready", pipe_in_ready, 1);
        idle_in();
        tick();
        check("drop_ferr_clr", frame_error, 0);
        check("drop_fcount", frame_count, 2);

        // Restart inside an open frame.
        out_ready = 1'b0;
        drive(8'hA0, 1, 0);
        tick();
        drive(8'hA1, 0, 0);
        tick();
        check("restart_ferr_pre", frame_error, 0);
        drive(8'hB0, 1, 1);
        tick();
        check("restart_ferr", frame_error, 1);
        check("restart_fcount", frame_count, 3);
        idle_in();
        out_ready = 1'b1;
        check("rs_0", {out_start, out_stop, out_data}, {2'b10, 8'hA0});
        tick();
        check("restart_ferr_clr", frame_error, 0);
        check("rs_1", {out_start, out_stop, out_data}, {2'b00, 8'hA1});
        tick();
        check("rs_2", {out_start, out_stop, out_data}, {2'b11, 8'hB0});
        tick();
        check("rs_empty", out_valid, 0);

        // Asynchronous reset mid-frame with five beats stored.
        out_ready = 1'b0;
        drive(8'hC0, 1, 0);
        tick();
        for (int i = 1; i < 5; i++) begin
            drive(8'hC0 + 8'(i), 0, 0);
            tick();
        end
        idle_in();
        check("pre_rst_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_ready", pipe_in_ready, 0);
        check("arst_fcount", frame_count, 0);
        check("arst_data", out_data, 0);
        tick();
        reset = 1'b0;
        drive(8'hD0, 0, 1);
        tick();
        check("post_rst_ferr", frame_error, 1);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_fcount", frame_count, 0);

        // Frame counter wrap.
        out_ready = 1'b1;
        drive(8'hE0, 1, 1);
        for (int i = 0; i < 65535; i++) begin
            @(posedge clock);
        end
        #1;
        check("wrap_pre", frame_count, 16'hFFFF);
        check("wrap_ready", pipe_in_ready, 1);
        tick();
        check("wrap_zero", frame_count, 16'h0000);
        check("wrap_ferr", frame_error, 0);
        idle_in();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
